// File: rtl/seg_scan.sv
// Stopwatch display stage: snapshots MM.SS.CC once per scan frame, converts to BCD
// serially and scans a 6-digit 7-segment display. Optional: SEG_SCAN_LEAD_ZERO_BLANK_EN.
module seg_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [6:0] ms_10_i,
    input  logic       freeze,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);
    // state    | meaning
    // IDLE     | waiting for a frame boundary
    // CONV_MIN | 7 double-dabble steps on clamped minutes
    // CONV_SEC | 7 double-dabble steps on clamped seconds
    // CONV_MS  | 7 double-dabble steps on clamped hundredths
    // COMMIT   | copy all six BCD digits to the display register at once
    typedef enum logic [2:0] {IDLE, CONV_MIN, CONV_SEC, CONV_MS, COMMIT} state_t;

    localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic          OFF     = SEG_ACTIVE_LOW;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          frame_end;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [6:0]  sh_q, snap_sec_q, snap_ms_q;
    logic [7:0]  acc_q, acc_step;
    logic [7:0]  bcd_min_q, bcd_sec_q, bcd_ms_q;
    logic [23:0] disp_q;
    logic [6:0]  min_c, sec_c, ms_c;

    logic [5:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    always_comb begin
        presc_d   = presc_q + 1'b1;
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (presc_q == PRE_MAX) begin
            presc_d   = '0;
            idx_d     = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            frame_end = (idx_q == 3'd5);
        end
    end

    always_comb begin
        min_c = (min_i > 6'd59)    ? 7'd59 : {1'b0, min_i};
        sec_c = (sec_i > 6'd59)    ? 7'd59 : {1'b0, sec_i};
        ms_c  = (ms_10_i > 7'd99)  ? 7'd99 : ms_10_i;
    end

    // One shift/add-3 step: adjust nibbles >= 5, then shift in the next binary MSB.
    always_comb begin
        logic [7:0] adj;
        adj        = acc_q;
        if (acc_q[3:0] >= 4'd5) adj[3:0] = acc_q[3:0] + 4'd3;
        if (acc_q[7:4] >= 4'd5) adj[7:4] = acc_q[7:4] + 4'd3;
        acc_step   = {adj[6:0], sh_q[6]};
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            snap_sec_q <= '0;
            snap_ms_q  <= '0;
            bcd_min_q  <= '0;
            bcd_sec_q  <= '0;
            bcd_ms_q   <= '0;
            disp_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_end && !freeze) begin
                        sh_q       <= min_c;
                        snap_sec_q <= sec_c;
                        snap_ms_q  <= ms_c;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= CONV_MIN;
                    end
                end
                CONV_MIN, CONV_SEC, CONV_MS: begin
                    acc_q <= acc_step;
                    sh_q  <= {sh_q[5:0], 1'b0};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        cnt_q <= '0;
                        acc_q <= '0;
                        case (state_q)
                            CONV_MIN: begin
                                bcd_min_q <= acc_step;
                                sh_q      <= snap_sec_q;
                                state_q   <= CONV_SEC;
                            end
                            CONV_SEC: begin
                                bcd_sec_q <= acc_step;
                                sh_q      <= snap_ms_q;
                                state_q   <= CONV_MS;
                            end
                            default: begin
                                bcd_ms_q  <= acc_step;
                                state_q   <= COMMIT;
                            end
                        endcase
                    end
                end
                COMMIT: begin
                    disp_q  <= {bcd_min_q, bcd_sec_q, bcd_ms_q};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        logic [3:0] digit;
        logic [6:0] seg_hi;
        logic       dp_hi;
        case (idx_q)
            3'd0:    digit = disp_q[3:0];
            3'd1:    digit = disp_q[7:4];
            3'd2:    digit = disp_q[11:8];
            3'd3:    digit = disp_q[15:12];
            3'd4:    digit = disp_q[19:16];
            default: digit = disp_q[23:20];
        endcase
        case (digit)
            4'd0:    seg_hi = 7'b0111111;
            4'd1:    seg_hi = 7'b0000110;
            4'd2:    seg_hi = 7'b1011011;
            4'd3:    seg_hi = 7'b1001111;
            4'd4:    seg_hi = 7'b1100110;
            4'd5:    seg_hi = 7'b1101101;
            4'd6:    seg_hi = 7'b1111101;
            4'd7:    seg_hi = 7'b0000111;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1101111;
            default: seg_hi = 7'b0000000;
        endcase
        dp_hi = (idx_q == 3'd2) || (idx_q == 3'd4);
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
        if (idx_q == 3'd5 && digit == 4'd0) begin
            seg_hi = 7'b0000000;
            dp_hi  = 1'b0;
        end
`endif
        an_d  = (6'b000001 << idx_q) ^ {6{OFF}};
        seg_d = seg_hi ^ {7{OFF}};
        dp_d  = dp_hi ^ OFF;
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= {6{OFF}};
            seg_q   <= {7{OFF}};
            dp_q    <= OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV = 8 (48-cycle frames), active-low outputs.
module tb_seg_scan;
    logic       clk_core = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] min_i = '0;
    logic [5:0] sec_i = '0;
    logic [6:0] ms_10_i = '0;
    logic       freeze = 1'b0;
    logic [5:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    int tests = 0;
    int fails = 0;
    int cyc;

    logic [6:0] seg_al [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [6:0] cap_seg [6];
    logic       cap_dp  [6];
    int         cap_bad;

    seg_scan #(.SCAN_DIV(8), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk_core(clk_core), .rst(rst), .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
        .freeze(freeze), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
    );

    always #5 clk_core = ~clk_core;

    always @(posedge clk_core or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // Records what each digit shows over one full 48-cycle scan; no checking here.
    task automatic capture_frame();
        for (int i = 0; i < 6; i++) begin
            cap_seg[i] = 'x;
            cap_dp[i]  = 1'bx;
        end
        cap_bad = 0;
        repeat (48) begin
            int n;
            @(negedge clk_core);
            n = 0;
            for (int i = 0; i < 6; i++)
                if (an_o[i] == 1'b0) begin
                    n++;
                    cap_seg[i] = seg_o;
                    cap_dp[i]  = dp_o;
                end
            if (n != 1) cap_bad++;
        end
    endtask

    task automatic settle();
        repeat (72) @(negedge clk_core);
    endtask

    task automatic wait_mod(input int r);
        int n;
        n = 0;
        @(negedge clk_core);
        while ((cyc % 48) != r && n < 200) begin
            @(negedge clk_core);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL wait_mod: cycle phase %0d not reached, got %0d", r, cyc % 48);
        end
    endtask

    task automatic test_reset();
        logic [5:0] exp_an;
        repeat (3) @(negedge clk_core);
        rst = 1'b0;
        #1;
        tests++;
        if (an_o !== 6'b111111 || seg_o !== BLANK || dp_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: an=%b seg=%b dp=%b, want 111111 1111111 1", an_o, seg_o, dp_o);
        end
        @(negedge clk_core);
        tests++;
        if (an_o !== 6'b111110 || seg_o !== 7'b1000000 || dp_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_first: an=%b seg=%b dp=%b, want 111110 1000000 1", an_o, seg_o, dp_o);
        end
        repeat (7) @(negedge clk_core);
        tests++;
        if (an_o !== 6'b111110) begin
            fails++;
            $display("FAIL reset_hold8: an=%b, want 111110", an_o);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_core);
            if (k > 1) repeat (7) @(negedge clk_core);
            exp_an = ~(6'b000001 << (k % 6));
            tests++;
            if (an_o !== exp_an) begin
                fails++;
                $display("FAIL rotate_%0d: an=%b, want %b", k, an_o, exp_an);
            end
        end
    endtask

    task automatic test_display();
        int exp_d [6] = '{6, 5, 4, 3, 2, 1};
        min_i = 6'd12; sec_i = 6'd34; ms_10_i = 7'd56;
        settle();
        capture_frame();
        tests++;
        if (cap_bad !== 0) begin
            fails++;
            $display("FAIL onehot: %0d bad cycles, want 0", cap_bad);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== seg_al[exp_d[i]]) begin
                fails++;
                $display("FAIL disp_seg idx%0d: %b, want %b", i, cap_seg[i], seg_al[exp_d[i]]);
            end
            tests++;
            if (cap_dp[i] !== ((i == 2 || i == 4) ? 1'b0 : 1'b1)) begin
                fails++;
                $display("FAIL disp_dp idx%0d: %b, want %b", i, cap_dp[i], (i == 2 || i == 4) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_freeze();
        int exp_d [6] = '{9, 0, 8, 0, 7, 0};
        min_i = '0; sec_i = '0; ms_10_i = '0;
        settle();
        freeze = 1'b1;
        min_i = 6'd7; sec_i = 6'd8; ms_10_i = 7'd9;
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (cap_seg[i] !== seg_al[0]) begin
                    fails++;
                    $display("FAIL frozen f%0d idx%0d: %b, want %b", f, i, cap_seg[i], seg_al[0]);
                end
            end
        end
        freeze = 1'b0;
        settle();
        capture_frame();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== seg_al[exp_d[i]]) begin
                fails++;
                $display("FAIL unfrozen idx%0d: %b, want %b", i, cap_seg[i], seg_al[exp_d[i]]);
            end
        end
    endtask

    task automatic test_clamp();
        int exp_d [6] = '{9, 9, 9, 5, 9, 5};
        min_i = 6'd63; sec_i = 6'd60; ms_10_i = 7'd127;
        settle();
        capture_frame();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== seg_al[exp_d[i]]) begin
                fails++;
                $display("FAIL clamp idx%0d: %b, want %b", i, cap_seg[i], seg_al[exp_d[i]]);
            end
        end
    endtask

    task automatic test_torn();
        int exp_d [6] = '{3, 3, 2, 2, 1, 1};
        wait_mod(47);
        min_i = 6'd11; sec_i = 6'd22; ms_10_i = 7'd33;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk_core);
            min_i = 6'(j + 40); sec_i = 6'(j * 2); ms_10_i = 7'(j * 3 + 50);
        end
        freeze = 1'b1;
        capture_frame();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== seg_al[exp_d[i]]) begin
                fails++;
                $display("FAIL torn idx%0d: %b, want %b", i, cap_seg[i], seg_al[exp_d[i]]);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        min_i = 6'd12; sec_i = 6'd34; ms_10_i = 7'd56;
        wait_mod(10);
        rst = 1'b1;
        #1;
        tests++;
        if (an_o !== 6'b111111 || seg_o !== BLANK || dp_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: an=%b seg=%b dp=%b, want 111111 1111111 1", an_o, seg_o, dp_o);
        end
        repeat (2) @(negedge clk_core);
        rst = 1'b0;
        @(negedge clk_core);
        tests++;
        if (an_o !== 6'b111110 || seg_o !== seg_al[0]) begin
            fails++;
            $display("FAIL mid_restart: an=%b seg=%b, want 111110 %b", an_o, seg_o, seg_al[0]);
        end
        capture_frame();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== seg_al[0]) begin
                fails++;
                $display("FAIL mid_zero idx%0d: %b, want %b", i, cap_seg[i], seg_al[0]);
            end
        end
    endtask

    task automatic test_lead_zero();
        logic [6:0] exp5;
        min_i = 6'd5; sec_i = '0; ms_10_i = '0;
        settle();
        capture_frame();
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
        exp5 = BLANK;
`else
        exp5 = seg_al[0];
`endif
        tests++;
        if (cap_seg[5] !== exp5 || cap_dp[5] !== 1'b1) begin
            fails++;
            $display("FAIL lead_min5 idx5: seg=%b dp=%b, want %b 1", cap_seg[5], cap_dp[5], exp5);
        end
        tests++;
        if (cap_seg[4] !== seg_al[5]) begin
            fails++;
            $display("FAIL lead_min5 idx4: %b, want %b", cap_seg[4], seg_al[5]);
        end
        min_i = 6'd15;
        settle();
        capture_frame();
        tests++;
        if (cap_seg[5] !== seg_al[1]) begin
            fails++;
            $display("FAIL lead_min15 idx5: %b, want %b", cap_seg[5], seg_al[1]);
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_freeze();
        test_clamp();
        test_torn();
        test_reset_mid();
        test_lead_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
